// File: rtl/lc3_mmio_pkg.sv
// Shared constants and types for the LC-3 MMIO console responder.
package lc3_mmio_pkg;

  localparam logic [15:0] MMIO_BASE = 16'hFE00;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

  localparam logic [7:0] KBD_VEC  = 8'h80;
  localparam logic [7:0] DISP_VEC = 8'h81;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} disp_state_t;

endpackage

// File: rtl/lc3_display_tx.sv
// Display transmit engine: holds one character, offers it with a
// valid/ready handshake, then idles DISP_DELAY cycles before accepting more.
module lc3_display_tx
  import lc3_mmio_pkg::*;
#(
  parameter int DISP_DELAY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       disp_valid,
  output logic [7:0] disp_data,
  input  logic       disp_ready
);

  localparam int CNT_W = (DISP_DELAY > 1) ? $clog2(DISP_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (DISP_DELAY > 0) ? CNT_W'(DISP_DELAY - 1) : '0;

  disp_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;

  // State, delay counter and character register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Next state: starts are only honoured in IDLE, so data_q never changes
  // while the character is being offered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = data;
          state_d = SEND;
        end
      end
      SEND: begin
        if (disp_ready) begin
          if (DISP_DELAY == 0) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign disp_valid = (state_q == SEND);
  assign disp_data  = data_q;

endmodule

// File: rtl/lc3_mmio_console.sv
// LC-3 device-page responder: keyboard, display and machine control
// registers plus the interrupt request lines fed back to the core.
module lc3_mmio_console
  import lc3_mmio_pkg::*;
#(
  parameter logic [2:0] KBD_PRI    = 3'd4,
  parameter logic [2:0] DISP_PRI   = 3'd4,
  parameter int         DISP_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mmio_addr,
  input  logic [15:0] mmio_wdata,
  input  logic        mmio_load,
  input  logic        mmio_rd,
  output logic [15:0] mmio_rdata,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  output logic        kbd_ready,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ready,
  output logic        run,
  output logic        IRQ,
  output logic [2:0]  INTP,
  output logic [7:0]  INTV
);

  logic       kbsr_rdy_q, kbsr_rdy_d;
  logic       kbsr_ie_q, kbsr_ie_d;
  logic [7:0] kbdr_q, kbdr_d;
  logic       dsr_ie_q, dsr_ie_d;
  logic       mcr_run_q, mcr_run_d;
  logic       src_q, src_d;
  logic       irq_q, irq_d;
  logic [2:0] intp_q, intp_d;
  logic [7:0] intv_q, intv_d;

  logic in_page, st, rd, disp_busy, req_k, req_d, take_k;
  logic unused_wdata;

  assign in_page      = (mmio_addr >= MMIO_BASE);
  assign st           = mmio_load & in_page;
  assign rd           = mmio_rd & in_page;
  assign unused_wdata = ^mmio_wdata[13:8];

  lc3_display_tx #(.DISP_DELAY(DISP_DELAY)) u_tx (
    .clk        (clk),
    .rst        (rst),
    .start      (st && mmio_addr == DDR_ADDR),
    .data       (mmio_wdata[7:0]),
    .busy       (disp_busy),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .disp_ready (disp_ready)
  );

  // Register file and interrupt output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kbsr_rdy_q <= 1'b0;
      kbsr_ie_q  <= 1'b0;
      kbdr_q     <= '0;
      dsr_ie_q   <= 1'b0;
      mcr_run_q  <= 1'b1;
      src_q      <= 1'b0;
      irq_q      <= 1'b0;
      intp_q     <= '0;
      intv_q     <= '0;
    end else begin
      kbsr_rdy_q <= kbsr_rdy_d;
      kbsr_ie_q  <= kbsr_ie_d;
      kbdr_q     <= kbdr_d;
      dsr_ie_q   <= dsr_ie_d;
      mcr_run_q  <= mcr_run_d;
      src_q      <= src_d;
      irq_q      <= irq_d;
      intp_q     <= intp_d;
      intv_q     <= intv_d;
    end
  end

  // Register updates: stores touch only their writable bits; capture is
  // backpressured by kbd_ready so it can never collide with a KBDR read.
  always_comb begin
    kbsr_rdy_d = kbsr_rdy_q;
    kbsr_ie_d  = kbsr_ie_q;
    kbdr_d     = kbdr_q;
    dsr_ie_d   = dsr_ie_q;
    mcr_run_d  = mcr_run_q;
    if (st) begin
      case (mmio_addr)
        KBSR_ADDR: kbsr_ie_d = mmio_wdata[14];
        DSR_ADDR:  dsr_ie_d  = mmio_wdata[14];
        MCR_ADDR:  mcr_run_d = mmio_wdata[15];
        default: ;
      endcase
    end
    if (kbd_valid && !kbsr_rdy_q) begin
      kbsr_rdy_d = 1'b1;
      kbdr_d     = kbd_data;
    end else if (rd && mmio_addr == KBDR_ADDR) begin
      kbsr_rdy_d = 1'b0;
    end
  end

  // Interrupt arbitration; after the last source drops, one cycle of
  // IRQ with priority 0 lets the core clear its latched priority.
  always_comb begin
    req_k  = kbsr_rdy_q & kbsr_ie_q;
    req_d  = ~disp_busy & dsr_ie_q;
    take_k = req_k && (!req_d || KBD_PRI >= DISP_PRI);
    src_d  = req_k | req_d;
    irq_d  = 1'b0;
    intp_d = '0;
    intv_d = '0;
    if (take_k) begin
      irq_d  = 1'b1;
      intp_d = KBD_PRI;
      intv_d = KBD_VEC;
    end else if (req_d) begin
      irq_d  = 1'b1;
      intp_d = DISP_PRI;
      intv_d = DISP_VEC;
    end else if (src_q) begin
      irq_d  = 1'b1;
    end
  end

  // Zero-latency read mux; unused bits and unmapped addresses read 0.
  always_comb begin
    mmio_rdata = '0;
    case (mmio_addr)
      KBSR_ADDR: mmio_rdata = {kbsr_rdy_q, kbsr_ie_q, 14'b0};
      KBDR_ADDR: mmio_rdata = {8'h00, kbdr_q};
      DSR_ADDR:  mmio_rdata = {~disp_busy, dsr_ie_q, 14'b0};
      DDR_ADDR:  mmio_rdata = {8'h00, disp_data};
      MCR_ADDR:  mmio_rdata = {mcr_run_q, 15'b0};
      default:   mmio_rdata = '0;
    endcase
  end

  assign kbd_ready = ~kbsr_rdy_q;
  assign run       = mcr_run_q;
  assign IRQ       = irq_q;
  assign INTP      = intp_q;
  assign INTV      = intv_q;

endmodule

// File: tb/tb_lc3_mmio_console.sv
// Bench for lc3_mmio_console: a main instance with DISP_PRI=6 and a second
// instance with equal priorities sharing the same stimulus.
module tb_lc3_mmio_console;

  logic        clk, rst;
  logic [15:0] mmio_addr, mmio_wdata;
  logic        mmio_load, mmio_rd;
  logic        kbd_valid;
  logic [7:0]  kbd_data;
  logic        disp_ready;

  logic [15:0] rdata, rdata_t;
  logic        kbd_ready, kbd_ready_t, disp_valid, disp_valid_t, run, run_t;
  logic [7:0]  disp_data, disp_data_t, intv, intv_t;
  logic        irq, irq_t;
  logic [2:0]  intp, intp_t;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];
  logic [15:0] e;

  lc3_mmio_console #(.KBD_PRI(3'd4), .DISP_PRI(3'd6), .DISP_DELAY(4)) dut (
    .clk(clk), .rst(rst), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .mmio_load(mmio_load), .mmio_rd(mmio_rd), .mmio_rdata(rdata),
    .kbd_valid(kbd_valid), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready),
    .run(run), .IRQ(irq), .INTP(intp), .INTV(intv)
  );

  lc3_mmio_console #(.KBD_PRI(3'd4), .DISP_PRI(3'd4), .DISP_DELAY(4)) dut_tie (
    .clk(clk), .rst(rst), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .mmio_load(mmio_load), .mmio_rd(mmio_rd), .mmio_rdata(rdata_t),
    .kbd_valid(kbd_valid), .kbd_data(kbd_data), .kbd_ready(kbd_ready_t),
    .disp_valid(disp_valid_t), .disp_data(disp_data_t), .disp_ready(disp_ready),
    .run(run_t), .IRQ(irq_t), .INTP(intp_t), .INTV(intv_t)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    mmio_addr = a; mmio_wdata = d; mmio_load = 1'b1;
    tick();
    mmio_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    sb.push_back(16'h8000); sb.push_back(16'h8000); sb.push_back(16'h0000);
    sb.push_back(16'h0000); sb.push_back(16'h0000);
    mmio_addr = 16'hFE04; #1; checks++; e = sb.pop_front();
    if (rdata !== e) begin errors++; $display("FAIL reset_dsr got %h exp %h", rdata, e); end
    mmio_addr = 16'hFFFE; #1; checks++; e = sb.pop_front();
    if (rdata !== e) begin errors++; $display("FAIL reset_mcr got %h exp %h", rdata, e); end
    mmio_addr = 16'hFE00; #1; checks++; e = sb.pop_front();
    if (rdata !== e) begin errors++; $display("FAIL reset_kbsr got %h exp %h", rdata, e); end
    mmio_addr = 16'hFE08; #1; checks++; e = sb.pop_front();
    if (rdata !== e) begin errors++; $display("FAIL unmapped_page got %h exp %h", rdata, e); end
    mmio_addr = 16'h3000; #1; checks++; e = sb.pop_front();
    if (rdata !== e) begin errors++; $display("FAIL below_page got %h exp %h", rdata, e); end
    checks++;
    if ({irq, kbd_ready, disp_valid, run} !== 4'b0101) begin
      errors++; $display("FAIL reset_flags got %b exp 0101", {irq, kbd_ready, disp_valid, run});
    end
  endtask

  task automatic test_keyboard();
    kbd_data = 8'h41; kbd_valid = 1'b1;
    tick();
    kbd_valid = 1'b0;
    sb.push_back(16'h8000); sb.push_back(16'h0041); sb.push_back(16'h0041);
    mmio_addr = 16'hFE00; #1; checks++; e = sb.pop_front();
    if (rdata !== e) begin errors++; $display("FAIL kbd_kbsr_full got %h exp %h", rdata, e); end
    mmio_addr = 16'hFE02; #1; checks++; e = sb.pop_front();
    if (rdata !== e) begin errors++; $display("FAIL kbd_kbdr got %h exp %h", rdata, e); end
    checks++;
    if (kbd_ready !== 1'b0) begin errors++; $display("FAIL kbd_ready_full got %b exp 0", kbd_ready); end
    // Stores to KBDR and to addresses below the page must not disturb state.
    store(16'hFE02, 16'h00FF);
    store(16'h1000, 16'h4000);
    mmio_addr = 16'hFE02; #1; checks++; e = sb.pop_front();
    if (rdata !== e) begin errors++; $display("FAIL kbdr_store_ignored got %h exp %h", rdata, e); end
    // A load strobe below the page is ignored.
    mmio_addr = 16'h0002; mmio_rd = 1'b1;
    tick();
    sb.push_back(16'h8000); sb.push_back(16'h0000);
    mmio_addr = 16'hFE00; #1; checks++; e = sb.pop_front();
    if (rdata !== e) begin errors++; $display("FAIL rd_below_page got %h exp %h", rdata, e); end
    mmio_addr = 16'hFE02;
    tick();
    mmio_rd = 1'b0;
    mmio_addr = 16'hFE00; #1; checks++; e = sb.pop_front();
    if (rdata !== e) begin errors++; $display("FAIL kbd_cleared got %h exp %h", rdata, e); end
    checks++;
    if (kbd_ready !== 1'b1) begin errors++; $display("FAIL kbd_ready_again got %b exp 1", kbd_ready); end
  endtask

  task automatic test_display();
    disp_ready = 1'b0;
    store(16'hFE06, 16'h0058);
    for (int i = 0; i < 3; i++) begin
      sb.push_back({7'd0, 1'b1, 8'h58});
      sb.push_back(16'h0000);
      mmio_addr = 16'hFE04; #1; checks++; e = sb.pop_front();
      if ({7'd0, disp_valid, disp_data} !== e) begin
        errors++; $display("FAIL disp_stall%0d got %b/%h exp %h", i, disp_valid, disp_data, e);
      end
      checks++; e = sb.pop_front();
      if (rdata !== e) begin errors++; $display("FAIL dsr_busy%0d got %h exp %h", i, rdata, e); end
      if (i == 1) store(16'hFE06, 16'h0077);
      else        tick();
    end
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;
    sb.push_back(16'h0058);
    mmio_addr = 16'hFE06; #1; checks++; e = sb.pop_front();
    if (rdata !== e) begin errors++; $display("FAIL ddr_drop got %h exp %h", rdata, e); end
    checks++;
    if (disp_valid !== 1'b0) begin errors++; $display("FAIL disp_valid_wait got %b exp 0", disp_valid); end
    mmio_addr = 16'hFE04;
    for (int k = 0; k <= 4; k++) begin
      sb.push_back((k == 4) ? 16'h8000 : 16'h0000);
      #1; checks++; e = sb.pop_front();
      if (rdata !== e) begin errors++; $display("FAIL dsr_delay%0d got %h exp %h", k, rdata, e); end
      if (k < 4) tick();
    end
  endtask

  task automatic test_kbd_irq();
    store(16'hFE00, 16'h4000);
    kbd_data = 8'h0D; kbd_valid = 1'b1;
    tick();
    kbd_valid = 1'b0;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency got %b exp 0", irq); end
    tick();
    sb.push_back({4'd0, 1'b1, 3'd4, 8'h80});
    checks++; e = sb.pop_front();
    if ({4'd0, irq, intp, intv} !== e) begin
      errors++; $display("FAIL kbd_irq got %b/%0d/%h exp %h", irq, intp, intv, e);
    end
    mmio_addr = 16'hFE02; mmio_rd = 1'b1;
    tick();
    mmio_rd = 1'b0;
    tick();
    sb.push_back({4'd0, 1'b1, 3'd0, 8'h00});
    sb.push_back(16'h0000);
    checks++; e = sb.pop_front();
    if ({4'd0, irq, intp, intv} !== e) begin
      errors++; $display("FAIL irq_clear_cycle got %b/%0d/%h exp %h", irq, intp, intv, e);
    end
    tick();
    checks++; e = sb.pop_front();
    if ({4'd0, irq, intp, intv} !== e) begin
      errors++; $display("FAIL irq_idle got %b/%0d/%h exp %h", irq, intp, intv, e);
    end
  endtask

  task automatic test_priority();
    store(16'hFE04, 16'h4000);
    kbd_data = 8'h33; kbd_valid = 1'b1;
    tick();
    kbd_valid = 1'b0;
    tick();
    sb.push_back({5'd0, 3'd6, 8'h81});
    sb.push_back({5'd0, 3'd4, 8'h80});
    checks++; e = sb.pop_front();
    if ({irq, 4'd0, intp, intv} !== {1'b1, e[14:0]}) begin
      errors++; $display("FAIL prio_disp got %b/%0d/%h exp 6/81", irq, intp, intv);
    end
    checks++; e = sb.pop_front();
    if ({irq_t, 4'd0, intp_t, intv_t} !== {1'b1, e[14:0]}) begin
      errors++; $display("FAIL prio_tie got %b/%0d/%h exp 4/80", irq_t, intp_t, intv_t);
    end
  endtask

  task automatic test_reset_mid_send();
    disp_ready = 1'b0;
    store(16'hFE06, 16'h0050);
    checks++;
    if (disp_valid !== 1'b1) begin errors++; $display("FAIL send_before_rst got %b exp 1", disp_valid); end
    #2 rst = 1'b1;
    #1;
    sb.push_back(16'h8000); sb.push_back(16'h8000); sb.push_back(16'h0000);
    checks++;
    if ({disp_valid, irq} !== 2'b00) begin
      errors++; $display("FAIL async_rst got %b exp 00", {disp_valid, irq});
    end
    mmio_addr = 16'hFE04; #1; checks++; e = sb.pop_front();
    if (rdata !== e) begin errors++; $display("FAIL rst_dsr got %h exp %h", rdata, e); end
    mmio_addr = 16'hFFFE; #1; checks++; e = sb.pop_front();
    if (rdata !== e) begin errors++; $display("FAIL rst_mcr got %h exp %h", rdata, e); end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (run !== 1'b1) begin errors++; $display("FAIL run_before got %b exp 1", run); end
    store(16'hFFFE, 16'h0000);
    checks++;
    if (run !== 1'b0) begin errors++; $display("FAIL run_cleared got %b exp 0", run); end
    mmio_addr = 16'hFFFE; #1; checks++; e = sb.pop_front();
    if (rdata !== e) begin errors++; $display("FAIL mcr_cleared got %h exp %h", rdata, e); end
  endtask

  initial begin
    rst = 1'b1; mmio_addr = '0; mmio_wdata = '0; mmio_load = 1'b0; mmio_rd = 1'b0;
    kbd_valid = 1'b0; kbd_data = '0; disp_ready = 1'b0;
    test_reset();
    test_keyboard();
    test_display();
    test_kbd_irq();
    test_priority();
    test_reset_mid_send();
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
